// File: rtl/sim_ctrl_pkg.sv
// Shared types and constants for the simulation run controller.
// Included by sim_ctrl, sim_ctrl_if users and sim_ctrl_trace.
package sim_ctrl_pkg;

   typedef enum logic [1:0] {
      S_RESET,
      S_RUN,
      S_DRAIN,
      S_DONE
   } state_e;

   typedef enum logic [1:0] {
      ST_NONE    = 2'd0,
      ST_PASS    = 2'd1,
      ST_FAIL    = 2'd2,
      ST_TIMEOUT = 2'd3
   } status_e;

   localparam logic [31:0] INST_EBREAK = 32'h00100073;

endpackage

// File: rtl/sim_ctrl_if.sv
// Commit stream and run-status bundle between bench/core and sim_ctrl.
// master drives the commit stream, slave is the controller.
interface sim_ctrl_if #(
   parameter int XLEN  = 32,
   parameter int CNT_W = 32
);

   logic             core_rst;
   logic             commit_valid;
   logic [XLEN-1:0]  commit_pc;
   logic [31:0]      commit_inst;
   logic [XLEN-1:0]  a0_value;
   logic             running;
   logic             done;
   logic [1:0]       status;
   logic [CNT_W-1:0] cycle_count;
   logic [CNT_W-1:0] instret_count;

   modport master (
      output commit_valid, commit_pc,
      output commit_inst, a0_value,
      input  core_rst, running, done, status,
      input  cycle_count, instret_count
   );

   modport slave (
      input  commit_valid, commit_pc,
      input  commit_inst, a0_value,
      output core_rst, running, done, status,
      output cycle_count, instret_count
   );

endinterface

// File: rtl/sim_ctrl_trace.sv
// Circular buffer of the most recently committed PCs.
// rd returns the entry idx places back from the newest write.
module sim_ctrl_trace #(
   parameter int XLEN  = 32,
   parameter int DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     we,
   input  logic [XLEN-1:0]          wpc,
   input  logic [$clog2(DEPTH)-1:0] idx,
   output logic [XLEN-1:0]          rd
);

   localparam int AW = $clog2(DEPTH);

   logic [XLEN-1:0] mem [DEPTH];
   logic [AW-1:0]   wr_ptr;
   logic [AW-1:0]   rd_ptr;

   // write newest PC and advance the pointer; reset clears every entry
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         for (int i = 0; i < DEPTH; i++)
            mem[i] <= '0;
      end else if (we) begin
         mem[wr_ptr] <= wpc;
         wr_ptr      <= wr_ptr + AW'(1);
      end
   end

   assign rd_ptr = wr_ptr - AW'(1) - idx;
   assign rd     = mem[rd_ptr];

endmodule

// File: rtl/sim_ctrl.sv
// Run controller: core reset, halt/timeout detect, counters, verdict.
// SIM_CTRL_TRACE_EN adds a committed-PC trace buffer.
import sim_ctrl_pkg::*;

module sim_ctrl #(
   parameter int          XLEN           = 32,
   parameter int          CNT_W          = 32,
   parameter int          RST_CYCLES     = 2,
   parameter int          DRAIN_CYCLES   = 3,
   parameter int          TIMEOUT_CYCLES = 50,
   parameter logic [31:0] HALT_INST      = INST_EBREAK
`ifdef SIM_CTRL_TRACE_EN
   ,
   parameter int          TRACE_DEPTH    = 8
`endif
) (
   input  logic clk,
   input  logic rst,
   sim_ctrl_if.slave bus
`ifdef SIM_CTRL_TRACE_EN
   ,
   input  logic [$clog2(TRACE_DEPTH)-1:0] trace_idx,
   output logic [XLEN-1:0]                trace_pc
`endif
);

   state_e           state_q, state_d;
   status_e          verdict_q, verdict_d;
   logic [31:0]      rst_cnt;
   logic [31:0]      drain_cnt;
   logic [CNT_W-1:0] cyc_q;
   logic [CNT_W-1:0] ins_q;
   logic             prev_valid;
   logic [XLEN-1:0]  prev_pc;
   logic [31:0]      prev_inst;
   logic             commit;
   logic             self_loop;
   logic             halt;
   logic             tmo;

   assign commit    = (state_q == S_RUN) && bus.commit_valid;
   assign self_loop = prev_valid
                    && (bus.commit_pc == prev_pc)
                    && (bus.commit_inst == prev_inst);
   assign halt      = commit
                    && ((bus.commit_inst == HALT_INST)
                        || self_loop);
   assign tmo       = (state_q == S_RUN)
                    && (TIMEOUT_CYCLES != 0)
                    && (cyc_q == CNT_W'(TIMEOUT_CYCLES - 1));

   // state and verdict registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_RESET;
         verdict_q <= ST_NONE;
      end else begin
         state_q   <= state_d;
         verdict_q <= verdict_d;
      end
   end

   // next state; halt takes priority over timeout in the same cycle
   always_comb begin
      state_d   = state_q;
      verdict_d = verdict_q;
      unique case (state_q)
         S_RESET: begin
            if (rst_cnt == 32'(RST_CYCLES - 1))
               state_d = S_RUN;
         end
         S_RUN: begin
            if (halt || tmo) begin
               state_d = (DRAIN_CYCLES == 0) ? S_DONE
                                             : S_DRAIN;
               if (halt)
                  verdict_d = (bus.a0_value == '0) ? ST_PASS
                                                   : ST_FAIL;
               else
                  verdict_d = ST_TIMEOUT;
            end
         end
         S_DRAIN: begin
            if (drain_cnt == 32'(DRAIN_CYCLES - 1))
               state_d = S_DONE;
         end
         S_DONE: begin
            state_d = S_DONE;
         end
         default: state_d = S_RESET;
      endcase
   end

   // sequencing counters, saturating run counters, previous commit
   always_ff @(posedge clk) begin
      if (rst) begin
         rst_cnt    <= '0;
         drain_cnt  <= '0;
         cyc_q      <= '0;
         ins_q      <= '0;
         prev_valid <= 1'b0;
         prev_pc    <= '0;
         prev_inst  <= '0;
      end else begin
         rst_cnt   <= (state_q == S_RESET) ? rst_cnt + 32'd1
                                           : '0;
         drain_cnt <= (state_q == S_DRAIN) ? drain_cnt + 32'd1
                                           : '0;
         if (state_q == S_RUN)
            cyc_q <= cyc_q + CNT_W'(cyc_q != '1);
         if (commit) begin
            ins_q      <= ins_q + CNT_W'(ins_q != '1);
            prev_valid <= 1'b1;
            prev_pc    <= bus.commit_pc;
            prev_inst  <= bus.commit_inst;
         end
      end
   end

   assign bus.core_rst      = (state_q == S_RESET);
   assign bus.running       = (state_q == S_RUN);
   assign bus.done          = (state_q == S_DONE);
   assign bus.status        = (state_q == S_DONE) ? verdict_q
                                                  : ST_NONE;
   assign bus.cycle_count   = cyc_q;
   assign bus.instret_count = ins_q;

`ifdef SIM_CTRL_TRACE_EN
   sim_ctrl_trace #(
      .XLEN  (XLEN),
      .DEPTH (TRACE_DEPTH)
   ) u_trace (
      .clk (clk),
      .rst (rst),
      .we  (commit),
      .wpc (bus.commit_pc),
      .idx (trace_idx),
      .rd  (trace_pc)
   );
`endif

endmodule
